dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits between the MEM stage of the 5-stage RV32I pipeline and an external data-memory bus; replaces the single-cycle data memory with a multi-cycle valid/ready interface.
- Formats byte/half/word loads and stores (funct3), holds the pipeline via StallM while an access is outstanding, and returns load data to the MEM/WB register.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles spent in WAIT before the access is aborted. Legal range is 1..65535.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- Funct3M  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, in the low bits
- ReadDataM  out  32  formatted load data, valid when StallM=0
- StallM  out  1  hold IF/ID/EX/MEM registers and bubble MEM/WB
- MisalignM  out  1  one-cycle pulse on a misaligned access
- BusErrM  out  1  one-cycle pulse on a timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables; 0000 on reads
- bus_rsp_valid  in  1  response or write ack, one cycle
- bus_rdata  in  32  read word

Behaviour:
- Access is defined as MemReadM|MemWriteM. If both are set, it is treated as a store.
- Alignment rules:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=00.
  - Any other funct3 on an access counts as misaligned.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No access: StallM=0.
  - Misaligned access: no bus activity, StallM=0, MisalignM=1 that cycle, ReadDataM=0, store suppressed. State stays IDLE.
  - Aligned access: StallM=1 combinationally. Latch addr, funct3, we, wdata and wstrb. Next state REQ.
- REQ:
  - bus_req_valid=1 with all bus_* outputs held stable until bus_req_ready.
  - On handshake go to WAIT and clear the timeout counter.
  - bus_rsp_valid is ignored in REQ; a response is never accepted in the same cycle as its request.
- WAIT:
  - The counter increments each cycle.
  - On bus_rsp_valid: capture the formatted load data (writes capture 0) and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without a response: go to DONE with data 0 and BusErrM=1 for the DONE cycle.
  - If bus_rsp_valid and timeout occur in the same cycle, the response wins and there is no error.
- DONE:
  - StallM=0 and ReadDataM=captured value for exactly one cycle, so the pipeline advances.
  - Next state IDLE.
  - The following instruction is evaluated in IDLE on the next cycle; there is no back-to-back skip.
- Latency: minimum 3 stall cycles per aligned access (IDLE, REQ, WAIT), with the result in the 4th cycle.
- StallM is 1 in IDLE(aligned access), REQ and WAIT.
- A stray bus_rsp_valid in IDLE, REQ or DONE is dropped. This covers late responses after a timeout.
- Store formatting:
  - SB: wdata={4{wd[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wd[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=wd, wstrb=1111.
- Load formatting:
  - Select the byte lane by addr[1:0] and the half lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- ReadDataM is 0 whenever not in DONE.
- Reset (async, any state):
  - State=IDLE; counter=0.
  - All bus_* outputs 0; ReadDataM=0; MisalignM=0; BusErrM=0.
  - StallM is driven combinationally from IDLE after reset.
  - An in-flight bus transaction is abandoned; its response is dropped per the stray rule.

Test Plan:
- LW addr 0x100, ready=1 immediately, rsp after 1 cycle with rdata=0xDEADBEEF -> StallM high 3 cycles, then ReadDataM=0xDEADBEEF for 1 cycle; bus_addr=0x100, wstrb=0000.
- LB addr 0x103 with rdata=0x80FF0000 -> ReadDataM=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201 with WriteDataM=0x000000A5 -> bus_we=1, bus_addr=0x200, wdata=0xA5A5A5A5, wstrb=0010. Hold ready=0 for 4 cycles -> outputs stable, StallM held high.
- SH addr 0x203 -> MisalignM pulses for 1 cycle, no bus_req_valid, StallM=0, ReadDataM=0.
- TIMEOUT_CYCLES=4, LW accepted, no rsp -> DONE after 4 WAIT cycles, BusErrM=1, ReadDataM=0. A late rsp_valid 2 cycles later is ignored, state stays IDLE.
- Assert reset low during WAIT -> bus_req_valid=0 and state IDLE immediately (async). After release, a fresh LW completes normally.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// MEM-stage bridge from the RV32I pipeline to a valid/ready data-memory bus.
// Formats sub-word loads/stores and stalls the pipeline while an access is in flight.
module dmem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } bridgeState;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridgeState state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rdReg;
  logic errReg;
  logic [2:0] f3Reg;
  logic [1:0] addrLo;

  logic access;
  logic aligned;
  logic latch;
  logic timeout;
  logic [31:0] stData;
  logic [3:0] stStrb;
  logic [31:0] ldData;
  logic [31:0] laneWord;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    aligned = 1'b0;
    case (Funct3M)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~ALUResultM[0];
      3'b010:         aligned = (ALUResultM[1:0] == 2'b00);
      default:        aligned = 1'b0;
    endcase
  end

  always_comb begin
    stData = WriteDataM;
    stStrb = 4'b1111;
    case (Funct3M[1:0])
      2'b00: begin
        stData = {4{WriteDataM[7:0]}};
        stStrb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        stData = {2{WriteDataM[15:0]}};
        stStrb = 4'b0011 << ALUResultM[1:0];
      end
      default: begin
        stData = WriteDataM;
        stStrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    laneWord = bus_rdata >> {addrLo, 3'b000};
    ldData = bus_rdata;
    case (f3Reg)
      3'b000: ldData = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b100: ldData = {24'd0, laneWord[7:0]};
      3'b001: ldData = addrLo[1] ? {{16{bus_rdata[31]}}, bus_rdata[31:16]}
                                 : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
      3'b101: ldData = addrLo[1] ? {16'd0, bus_rdata[31:16]}
                                 : {16'd0, bus_rdata[15:0]};
      default: ldData = bus_rdata;
    endcase
  end

  always_comb begin
    nextState = state;
    StallM = 1'b0;
    MisalignM = 1'b0;
    bus_req_valid = 1'b0;
    latch = 1'b0;
    timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && aligned) begin
          StallM = 1'b1;
          latch = 1'b1;
          nextState = REQ;
        end else if (access) begin
          MisalignM = reset;
        end
      end
      REQ: begin
        StallM = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) nextState = WAIT;
      end
      WAIT: begin
        StallM = 1'b1;
        if (bus_rsp_valid) begin
          nextState = DONE;
        end else if (cnt == LAST) begin
          timeout = 1'b1;
          nextState = DONE;
        end
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign ReadDataM = (state == DONE) ? rdReg : 32'd0;
  assign BusErrM = (state == DONE) & errReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rdReg <= 32'd0;
      errReg <= 1'b0;
      f3Reg <= 3'd0;
      addrLo <= 2'd0;
      bus_we <= 1'b0;
      bus_addr <= 32'd0;
      bus_wdata <= 32'd0;
      bus_wstrb <= 4'd0;
    end else begin
      state <= nextState;
      if (latch) begin
        f3Reg <= Funct3M;
        addrLo <= ALUResultM[1:0];
        bus_we <= MemWriteM;
        bus_addr <= {ALUResultM[31:2], 2'b00};
        bus_wdata <= stData;
        bus_wstrb <= MemWriteM ? stStrb : 4'b0000;
      end
      if (state == REQ && bus_req_ready) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      // Response beats the timeout when both land in the same cycle.
      if (state == WAIT && bus_rsp_valid) begin
        rdReg <= bus_we ? 32'd0 : ldData;
        errReg <= 1'b0;
      end else if (timeout) begin
        rdReg <= 32'd0;
        errReg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: transaction-level model of the bridge
// driving directed and random accesses, checked every cycle.
module tb_dmem_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'd0;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .MemReadM(MemReadM),
    .MemWriteM(MemWriteM),
    .Funct3M(Funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM),
    .StallM(StallM),
    .MisalignM(MisalignM),
    .BusErrM(BusErrM),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        chkEn = 1'b0;
  logic        chkBus = 1'b0;
  logic        expStall = 1'b0;
  logic        expMis = 1'b0;
  logic        expErr = 1'b0;
  logic        expValid = 1'b0;
  logic        expWe = 1'b0;
  logic [31:0] expRd = 32'd0;
  logic [31:0] expAddr = 32'd0;
  logic [31:0] expWdata = 32'd0;
  logic [3:0]  expStrb = 4'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      chk("StallM", 32'(StallM), 32'(expStall));
      chk("MisalignM", 32'(MisalignM), 32'(expMis));
      chk("BusErrM", 32'(BusErrM), 32'(expErr));
      chk("ReadDataM", ReadDataM, expRd);
      chk("bus_req_valid", 32'(bus_req_valid), 32'(expValid));
      if (chkBus) begin
        chk("bus_we", 32'(bus_we), 32'(expWe));
        chk("bus_addr", bus_addr, expAddr);
        chk("bus_wstrb", 32'(bus_wstrb), 32'(expStrb));
        if (expWe) chk("bus_wdata", bus_wdata, expWdata);
      end
    end
  end

  function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                            input logic [1:0] lo,
                                            input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (lo * 8)) & 32'hFF;
    h = (w >> (lo[1] * 16)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic modelAligned(input logic [2:0] f3,
                                        input logic [31:0] a);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
    if (f3 == 3'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic int modelSize(input logic [2:0] f3);
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3,
                                           input logic [31:0] a);
    int m;
    m = ((1 << modelSize(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3,
                                             input logic [31:0] wd);
    if (modelSize(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (modelSize(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearExp();
    expStall = 1'b0;
    expMis = 1'b0;
    expErr = 1'b0;
    expValid = 1'b0;
    expRd = 32'd0;
    chkBus = 1'b0;
  endtask

  task automatic idleCycle(input logic rsp);
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = rsp;
    bus_rdata = $urandom;
    clearExp();
    nextCycle();
  endtask

  task automatic doAccess(input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int rdyDly,
                          input int rspDly, input logic [31:0] rdata,
                          input logic stray, input logic usePin,
                          input logic [31:0] pinRd,
                          input logic [31:0] pinWd,
                          input logic [3:0] pinStrb);
    logic tmo;
    int nW;
    MemReadM = rd;
    MemWriteM = wr;
    Funct3M = f3;
    ALUResultM = a;
    WriteDataM = wd;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata = $urandom;
    clearExp();
    if (!(rd | wr)) begin
      nextCycle();
      return;
    end
    if (!modelAligned(f3, a)) begin
      expMis = 1'b1;
      bus_rsp_valid = stray;
      nextCycle();
      clearExp();
      return;
    end
    expStall = 1'b1;
    bus_rsp_valid = stray;
    nextCycle();
    expValid = 1'b1;
    chkBus = 1'b1;
    expWe = wr;
    expAddr = a & ~32'd3;
    expStrb = wr ? (usePin ? pinStrb : modelStrb(f3, a)) : 4'd0;
    expWdata = usePin ? pinWd : modelWdata(f3, wd);
    for (int i = 0; i < rdyDly; i++) begin
      bus_rsp_valid = stray && (i == 0);
      nextCycle();
    end
    bus_req_ready = 1'b1;
    bus_rsp_valid = stray;
    nextCycle();
    bus_req_ready = 1'b0;
    expValid = 1'b0;
    chkBus = 1'b0;
    tmo = (rspDly >= TO);
    nW = tmo ? TO : rspDly + 1;
    for (int i = 0; i < nW; i++) begin
      bus_rsp_valid = !tmo && (i == rspDly);
      bus_rdata = bus_rsp_valid ? rdata : $urandom;
      nextCycle();
    end
    bus_rsp_valid = stray;
    bus_rdata = $urandom;
    expStall = 1'b0;
    expErr = tmo;
    if (tmo || wr) expRd = 32'd0;
    else expRd = usePin ? pinRd : modelLoad(f3, a[1:0], rdata);
    nextCycle();
    bus_rsp_valid = 1'b0;
    clearExp();
  endtask

  initial begin
    nextCycle();
    nextCycle();
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_rd", ReadDataM, 32'd0);
    reset = 1'b1;
    chkEn = 1'b1;
    idleCycle(1'b0);

    doAccess(1, 0, 3'd2, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0, 1,
             32'hDEADBEEF, 0, 4'd0);
    doAccess(1, 0, 3'd0, 32'h103, 0, 0, 0, 32'h80FF0000, 0, 1,
             32'hFFFFFF80, 0, 4'd0);
    doAccess(1, 0, 3'd4, 32'h103, 0, 0, 0, 32'h80FF0000, 0, 1,
             32'h00000080, 0, 4'd0);
    doAccess(1, 0, 3'd5, 32'h102, 0, 0, 0, 32'h80FF0000, 0, 1,
             32'h000080FF, 0, 4'd0);
    doAccess(0, 1, 3'd0, 32'h201, 32'hA5, 4, 0, 0, 0, 1,
             0, 32'hA5A5A5A5, 4'b0010);
    doAccess(0, 1, 3'd1, 32'h203, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    doAccess(1, 0, 3'd2, 32'h104, 0, 0, TO, 32'h11111111, 0, 1,
             0, 0, 4'd0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);

    // Reset asserted mid-WAIT, with a stray response while held.
    chkEn = 1'b0;
    MemReadM = 1'b1;
    Funct3M = 3'd2;
    ALUResultM = 32'h300;
    nextCycle();
    bus_req_ready = 1'b1;
    nextCycle();
    bus_req_ready = 1'b0;
    nextCycle();
    chk("wait_stall", 32'(StallM), 32'd1);
    chk("wait_addr", bus_addr, 32'h300);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_req_valid), 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_stall", 32'(StallM), 32'd1);
    chk("arst_rd", ReadDataM, 32'd0);
    chk("arst_err", 32'(BusErrM), 32'd0);
    MemReadM = 1'b0;
    bus_rsp_valid = 1'b1;
    nextCycle();
    bus_rsp_valid = 1'b0;
    reset = 1'b1;
    chkEn = 1'b1;
    idleCycle(1'b1);
    doAccess(1, 0, 3'd2, 32'h400, 0, 1, 2, 32'hCAFEF00D, 0, 1,
             32'hCAFEF00D, 0, 4'd0);

    for (int n = 0; n < 200; n++) begin
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      rd = (kind <= 5) || (kind == 9);
      wr = (kind >= 6);
      if (kind == 8) rd = 1'b0;
      if (kind == 7 && ($urandom_range(0, 3) == 0)) rd = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      if ($urandom_range(0, 19) == 0) f3 = 3'd3 + 3'($urandom_range(0, 1)) * 3'd3;
      a = 32'h1000 + ($urandom & 32'h0FFF);
      doAccess(rd, wr, f3, a, $urandom, $urandom_range(0, 3),
               $urandom_range(0, TO + 1), $urandom,
               1'($urandom_range(0, 1)), 0, 0, 0, 4'd0);
    end

    idleCycle(1'b0);
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
